fetch_sequencer: RTL and testbench

- Upstream neighbour of the instruction memory. Owns the 13-bit word-addressed program counter and selects the next PC each clock from sequential, branch, jump and jump-register sources.
- Adds stall, end-of-program halt, a taken-redirect pulse and a retired-instruction counter.
- Its pc output drives the instruction memory read address directly. It replaces the free-running pc+1 loop and the simulation-stop on program end.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Owns the word-addressed program counter that feeds the instruction memory
// read address. Each clock it picks the next PC from the sequential, branch,
// jump and jump-register sources. It also handles stall, a sticky
// end-of-program halt, a one-cycle redirect pulse and a saturating
// retired-instruction counter.
//
// Ports:
//   clk            master clock; all state changes on posedge
//   reset          synchronous active-high reset (highest priority)
//   stall          hold pc and drop every redirect request this cycle
//   branch_taken   conditional branch resolved taken
//   branch_offset  signed word offset, relative to pc+1
//   jump           J/JAL request; target is jump_target[PC_W-1:0]
//   jump_target    instruction target field
//   jr             jump-register request; target is jr_addr[PC_W-1:0]
//   jr_addr        register value used as a word address
//   pc             registered fetch address
//   pc_plus1       pc+1 modulo 2^PC_W (link value / branch base)
//   fetch_valid    pc is a valid fetch address (RUN state)
//   halted         sticky end-of-program flag (HALT state)
//   redirect       high for one cycle after a taken non-sequential update
//   instr_count    saturating count of pc advances (retired instructions)
//
// PC_W must be at most 26 so that both target fields cover it.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int PC_W      = 13,
    parameter int PROG_SIZE = 8192,
    parameter int RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jr,
    input  logic [31:0]     jr_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            fetch_valid,
    output logic            halted,
    output logic            redirect,
    output logic [31:0]     instr_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Limits compared against a 33-bit candidate so that the unwrapped
    // sequential step (pc+1 with carry) is caught as out of program.
    localparam logic [32:0]     PROG_END    = 33'(PROG_SIZE);
    localparam bit              RESET_HALTS = (RESET_PC >= PROG_SIZE);
    localparam logic [PC_W-1:0] RESET_PC_V  = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     count_q;
    logic            redirect_q, redirect_d;
    logic            advance;
    logic            take_redirect;
    logic [32:0]     target_ext;
    logic [31:0]     branch_sum;
    logic            unused_bits;

    // Branch base is pc+1; the sum is truncated to PC_W so wrap-around is
    // simply modular arithmetic.
    assign branch_sum = 32'(pc_plus1) + {{16{branch_offset[15]}}, branch_offset};

    // Target bits above PC_W are deliberately ignored.
    assign unused_bits = ^{jump_target, jr_addr, branch_sum};

    // Next-state / next-pc selection. The candidate target is computed with
    // one spare bit so a single >= PROG_END test covers both a redirect past
    // the program and a sequential step off its end (including the 2^PC_W
    // wrap). On the halting edge pc holds while the count still advances.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_d    = 1'b0;
        advance       = 1'b0;
        take_redirect = 1'b0;
        target_ext    = 33'(pc_q) + 33'd1;

        if (jr) begin
            target_ext    = 33'(jr_addr[PC_W-1:0]);
            take_redirect = 1'b1;
        end else if (jump) begin
            target_ext    = 33'(jump_target[PC_W-1:0]);
            take_redirect = 1'b1;
        end else if (branch_taken) begin
            target_ext    = 33'(branch_sum[PC_W-1:0]);
            take_redirect = 1'b1;
        end

        if (state_q == RUN && !stall) begin
            advance = 1'b1;
            if (target_ext >= PROG_END) begin
                state_d = HALT;
            end else begin
                pc_d       = target_ext[PC_W-1:0];
                redirect_d = take_redirect;
            end
        end
    end

    // State register plus pc, redirect pulse and saturating counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_HALTS ? HALT : RUN;
            pc_q       <= RESET_PC_V;
            count_q    <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            if (advance && count_q != 32'hFFFF_FFFF) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign pc          = pc_q;
    assign pc_plus1    = pc_q + PC_W'(1);
    assign fetch_valid = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign redirect    = redirect_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Three instances: the default 8192-word configuration (sel 0), a 6-word
// program (sel 1) and a 6-word program whose reset PC lies outside it
// (sel 2). Each vector drives inputs at the falling edge, pushes its expected
// post-edge outputs onto a scoreboard queue, and the result is popped and
// compared 1 time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    typedef struct packed {
        logic [1:0]  sel;
        logic        rst;
        logic        stall;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic        jr;
        logic [31:0] jra;
        logic [12:0] exp_pc;
        logic [31:0] exp_cnt;
        logic        exp_redir;
        logic        exp_halt;
    } vec_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [12:0] pc;
        logic [31:0] cnt;
        logic        redir;
        logic        halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_main, rst_six;
    logic        stall, branch_taken, jump, jr;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] jr_addr;

    logic [12:0] pc0, pp0, pc1, pp1, pc2, pp2;
    logic        fv0, hl0, rd0, fv1, hl1, rd1, fv2, hl2, rd2;
    logic [31:0] ic0, ic1, ic2;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(rst_main), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr), .pc(pc0), .pc_plus1(pp0),
        .fetch_valid(fv0), .halted(hl0), .redirect(rd0), .instr_count(ic0)
    );

    fetch_sequencer #(.PC_W(13), .PROG_SIZE(6), .RESET_PC(0)) dut_six (
        .clk(clk), .reset(rst_six), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr), .pc(pc1), .pc_plus1(pp1),
        .fetch_valid(fv1), .halted(hl1), .redirect(rd1), .instr_count(ic1)
    );

    fetch_sequencer #(.PC_W(13), .PROG_SIZE(6), .RESET_PC(8)) dut_rh (
        .clk(clk), .reset(rst_main), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .jr(jr), .jr_addr(jr_addr), .pc(pc2), .pc_plus1(pp2),
        .fetch_valid(fv2), .halted(hl2), .redirect(rd2), .instr_count(ic2)
    );

    function automatic vec_t mk(input logic [1:0] sel, input logic rst, input logic stl,
                                input logic br, input logic [15:0] off,
                                input logic jmp, input logic [25:0] tgt,
                                input logic jrq, input logic [31:0] jra,
                                input logic [12:0] epc, input logic [31:0] ecnt,
                                input logic erd, input logic ehl);
        vec_t v;
        v.sel = sel; v.rst = rst; v.stall = stl; v.br = br; v.off = off;
        v.jmp = jmp; v.tgt = tgt; v.jr = jrq; v.jra = jra;
        v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_redir = erd; v.exp_halt = ehl;
        return v;
    endfunction

    function automatic vec_t v_rst(input logic [1:0] sel, input logic [12:0] epc, input logic ehl);
        return mk(sel, 1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, epc, 32'd0, 0, ehl);
    endfunction

    function automatic vec_t v_seq(input logic [1:0] sel, input logic [12:0] epc,
                                   input logic [31:0] ecnt, input logic ehl);
        return mk(sel, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, epc, ecnt, 0, ehl);
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_main      = (v.sel != 2'd1) ? v.rst : 1'b1;
        rst_six       = (v.sel == 2'd1) ? v.rst : 1'b1;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_offset = v.off;
        jump          = v.jmp;
        jump_target   = v.tgt;
        jr            = v.jr;
        jr_addr       = v.jra;
        e.sel = v.sel; e.pc = v.exp_pc; e.cnt = v.exp_cnt;
        e.redir = v.exp_redir; e.halt = v.exp_halt;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [12:0] a_pc, a_pp, e_pp;
        logic [31:0] a_cnt;
        logic        a_rd, a_hl, a_fv;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue, want an entry", vectors);
            return;
        end
        e = sb.pop_front();
        case (e.sel)
            2'd0:    begin a_pc = pc0; a_pp = pp0; a_cnt = ic0; a_rd = rd0; a_hl = hl0; a_fv = fv0; end
            2'd1:    begin a_pc = pc1; a_pp = pp1; a_cnt = ic1; a_rd = rd1; a_hl = hl1; a_fv = fv1; end
            default: begin a_pc = pc2; a_pp = pp2; a_cnt = ic2; a_rd = rd2; a_hl = hl2; a_fv = fv2; end
        endcase
        e_pp = e.pc + 13'd1;
        if (a_pc !== e.pc || a_pp !== e_pp || a_cnt !== e.cnt || a_rd !== e.redir ||
            a_hl !== e.halt || a_fv !== !e.halt) begin
            miscompares++;
            $display("[TB] FAIL vec%0d dut%0d: got pc=%h p1=%h cnt=%h rd=%b hl=%b fv=%b, want pc=%h p1=%h cnt=%h rd=%b hl=%b fv=%b",
                     vectors, e.sel, a_pc, a_pp, a_cnt, a_rd, a_hl, a_fv,
                     e.pc, e_pp, e.cnt, e.redir, e.halt, !e.halt);
        end
    endtask

    task automatic run_vec(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_main = 1; rst_six = 1; stall = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_offset = '0; jump_target = '0; jr_addr = '0;
        repeat (2) @(posedge clk);

        // Reset PC outside the program comes up halted and ignores requests.
        tbl.push_back(v_rst(2, 13'd8, 1));
        tbl.push_back(mk(2, 0, 0, 0, 16'h0, 1, 26'd3, 0, 32'h0, 13'd8, 32'd0, 0, 1));

        // Default configuration.
        tbl.push_back(v_rst(0, 13'd0, 0));
        for (int i = 1; i <= 10; i++) tbl.push_back(v_seq(0, 13'(i), 32'(i), 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'hFFFD, 0, 26'h0, 0, 32'h0, 13'd8, 32'd11, 1, 0));
        tbl.push_back(v_seq(0, 13'd9, 32'd12, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0, 1, 26'd2, 0, 32'h0, 13'd2, 32'd13, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'h7FF0, 0, 26'h0, 0, 32'h0, 13'h1FF3, 32'd14, 1, 0));
        tbl.push_back(v_seq(0, 13'h1FF4, 32'd15, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'd5, 1, 26'h100, 1, 32'h40, 13'h040, 32'd16, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 1, 1, 16'd7, 1, 26'h200, 1, 32'h99, 13'h040, 32'd16, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'd9, 1, 26'h100, 0, 32'h0, 13'h100, 32'd17, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_E123, 13'h123, 32'd18, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0, 1, 26'h200_0456, 0, 32'h0, 13'h456, 32'd19, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 16'hFB00, 0, 26'h0, 0, 32'h0, 13'h1F57, 32'd20, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0, 1, 26'h1FFF, 0, 32'h0, 13'h1FFF, 32'd21, 1, 0));
        tbl.push_back(v_seq(0, 13'h1FFF, 32'd22, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0, 1, 26'd5, 0, 32'h0, 13'h1FFF, 32'd22, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0, 1, 26'd5, 0, 32'h0, 13'd0, 32'd0, 0, 0));
        tbl.push_back(v_seq(0, 13'd1, 32'd1, 0));

        // Six-word program.
        tbl.push_back(v_rst(1, 13'd0, 0));
        for (int i = 1; i <= 5; i++) tbl.push_back(v_seq(1, 13'(i), 32'(i), 0));
        tbl.push_back(v_seq(1, 13'd5, 32'd6, 1));
        tbl.push_back(v_seq(1, 13'd5, 32'd6, 1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0, 1, 26'd1, 0, 32'h0, 13'd5, 32'd6, 0, 1));
        tbl.push_back(v_rst(1, 13'd0, 0));
        tbl.push_back(v_seq(1, 13'd1, 32'd1, 0));
        tbl.push_back(v_seq(1, 13'd2, 32'd2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0, 1, 26'd7, 0, 32'h0, 13'd2, 32'd3, 0, 1));
        tbl.push_back(v_rst(1, 13'd0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'd5, 13'd5, 32'd1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 16'hFFFF, 0, 26'h0, 0, 32'h0, 13'd5, 32'd2, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 16'h0000, 0, 26'h0, 0, 32'h0, 13'd5, 32'd3, 0, 1));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Counter saturation: preload near the top, then keep advancing.
        run_vec(v_rst(0, 13'd0, 0));
        run_vec(v_seq(0, 13'd1, 32'd1, 0));
        dut.count_q = 32'hFFFF_FFFE;
        run_vec(v_seq(0, 13'd2, 32'hFFFF_FFFF, 0));
        run_vec(v_seq(0, 13'd3, 32'hFFFF_FFFF, 0));
        run_vec(mk(0, 0, 1, 0, 16'h0, 1, 26'h10, 0, 32'h0, 13'd3, 32'hFFFF_FFFF, 0, 0));
        run_vec(mk(0, 0, 0, 0, 16'h0, 1, 26'h10, 0, 32'h0, 13'h010, 32'hFFFF_FFFF, 1, 0));

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
